magnitude_window_3x3: RTL and testbench

Streaming 3x3 neighbourhood generator for the Canny pipeline. It sits directly upstream of the double-threshold stage and consumes the raster-order gradient-magnitude stream (post non-maximum suppression). It buffers two image lines and presents a 3x3 window centred on one pixel, with a clock-enable and a border/invalid flag, in exactly the form the threshold stage consumes. It is pure streaming with no backpressure; the window advances only on accepted pixels.

---
 rtl/canny_pkg.sv | 19 +
 rtl/line_buffer.sv | 37 +++
 rtl/magnitude_window_3x3.sv | 152 +++++++++++++++
 tb/tb_magnitude_window_3x3.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// rtl/canny_pkg.sv - shared pixel types and frame defaults for the Canny pipeline
//
// Purpose: common constants and the magnitude pixel type shared between the
// 3x3 window generator and the double-threshold stage.
// Ports: none (package).

package canny_pkg;

  // Gradient-magnitude sample width after non-maximum suppression.
  localparam int PIX_DW          = 16;

  // Default frame geometry (VGA).
  localparam int IMG_WIDTH_DEF   = 640;
  localparam int IMG_HEIGHT_DEF  = 480;

  // Magnitude pixel as exchanged with the threshold stage.
  typedef logic [PIX_DW-1:0] pixel_t;

endpackage : canny_pkg

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - single-port line memory with read-old-during-write
//
// Purpose: one image line of storage. The read is combinational on the same
// address that is written at the clock edge, so a read in the write cycle
// returns the value stored before that write.
// Ports:
//   clk    in   clock, write on rising edge
//   we     in   write enable
//   addr   in   shared read/write address (column)
//   wdata  in   data written at addr when we is high
//   rdata  out  current (pre-write) contents at addr

module line_buffer #(
  parameter  int DEPTH = 640,
  parameter  int DW    = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Contents are intentionally not reset: downstream validity flags mask
  // any window that could still see uninitialised entries.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  assign rdata = r_mem[addr];

endmodule : line_buffer

// File: rtl/magnitude_window_3x3.sv
// rtl/magnitude_window_3x3.sv - streaming 3x3 neighbourhood generator for magnitude pixels
//
// Purpose: buffers two lines of the raster-order magnitude stream and presents
// a 3x3 window (centre = pixel at row-1, col-1 of the accepted pixel) to the
// double-threshold stage, with a per-accept clock enable, an invalid/border
// flag and an end-of-frame pulse. No backpressure; window moves only on accept.
// Ports:
//   clk            in   single clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   stage enable; low clears the scan position
//   pixel_valid    in   pixel_data accepted when high together with start
//   pixel_data     in   magnitude sample, raster order
//   matrix_clken   out  one-cycle pulse per accepted pixel (window updated)
//   data_valid     out  1 = window invalid (border / incomplete), 0 = usable
//   matrix_p11..33 out  window pixels, p11 top-left, p22 centre, p33 bottom-right
//   frame_done     out  pulse with the window of the last pixel of a frame

module magnitude_window_3x3
  import canny_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int DW         = PIX_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          pixel_valid,
  input  logic [DW-1:0] pixel_data,
  output logic          matrix_clken,
  output logic          data_valid,
  output logic [DW-1:0] matrix_p11,
  output logic [DW-1:0] matrix_p12,
  output logic [DW-1:0] matrix_p13,
  output logic [DW-1:0] matrix_p21,
  output logic [DW-1:0] matrix_p22,
  output logic [DW-1:0] matrix_p23,
  output logic [DW-1:0] matrix_p31,
  output logic [DW-1:0] matrix_p32,
  output logic [DW-1:0] matrix_p33,
  output logic          frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  // Scan position of the next pixel to be accepted.
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  // Window registers, column 3 is the newest column.
  logic [DW-1:0] r_p11, r_p12, r_p13;
  logic [DW-1:0] r_p21, r_p22, r_p23;
  logic [DW-1:0] r_p31, r_p32, r_p33;

  logic          r_clken;
  logic          r_dv;
  logic          r_done;

  logic          w_accept;
  logic          w_col_last;
  logic          w_row_last;
  logic [DW-1:0] w_lb1;        // line row-1 at current column
  logic [DW-1:0] w_lb2;        // line row-2 at current column
  logic [2*DW-1:0] w_lb_rd;

  assign w_accept   = start && pixel_valid;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);

  // Both lines live in one memory word {row-2, row-1}: on each accept the
  // row-1 value ages into the row-2 half and the new pixel takes its place.
  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .DW    (2 * DW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (w_accept),
    .addr  (r_col),
    .wdata ({w_lb1, pixel_data}),
    .rdata (w_lb_rd)
  );

  assign w_lb1 = w_lb_rd[DW-1:0];
  assign w_lb2 = w_lb_rd[2*DW-1:DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_clken <= 1'b0;
      r_dv    <= 1'b1;
      r_done  <= 1'b0;
      r_p11   <= '0;
      r_p12   <= '0;
      r_p13   <= '0;
      r_p21   <= '0;
      r_p22   <= '0;
      r_p23   <= '0;
      r_p31   <= '0;
      r_p32   <= '0;
      r_p33   <= '0;
    end else begin
      r_clken <= w_accept;
      r_done  <= w_accept && w_col_last && w_row_last;

      if (!start) begin
        // Idle: restart from the top-left; window and line memory hold.
        r_col <= '0;
        r_row <= '0;
      end else if (w_accept) begin
        // First two rows/columns of every frame lack a full neighbourhood;
        // at col 0/1 the left columns still carry the previous line's tail.
        r_dv <= (r_row < RW'(2)) || (r_col < CW'(2));

        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end

        r_p11 <= r_p12;
        r_p12 <= r_p13;
        r_p13 <= w_lb2;
        r_p21 <= r_p22;
        r_p22 <= r_p23;
        r_p23 <= w_lb1;
        r_p31 <= r_p32;
        r_p32 <= r_p33;
        r_p33 <= pixel_data;
      end
    end
  end

  assign matrix_clken = r_clken;
  assign data_valid   = r_dv;
  assign frame_done   = r_done;
  assign matrix_p11   = r_p11;
  assign matrix_p12   = r_p12;
  assign matrix_p13   = r_p13;
  assign matrix_p21   = r_p21;
  assign matrix_p22   = r_p22;
  assign matrix_p23   = r_p23;
  assign matrix_p31   = r_p31;
  assign matrix_p32   = r_p32;
  assign matrix_p33   = r_p33;

endmodule : magnitude_window_3x3

// File: tb/tb_magnitude_window_3x3.sv
// tb/tb_magnitude_window_3x3.sv - directed self-checking bench for magnitude_window_3x3

module tb_magnitude_window_3x3;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          pixel_valid;
  logic [DW-1:0] pixel_data;
  logic          matrix_clken;
  logic          data_valid;
  logic          frame_done;
  logic [DW-1:0] matrix_p11, matrix_p12, matrix_p13;
  logic [DW-1:0] matrix_p21, matrix_p22, matrix_p23;
  logic [DW-1:0] matrix_p31, matrix_p32, matrix_p33;

  logic [9*DW-1:0] w_win;
  assign w_win = {matrix_p11, matrix_p12, matrix_p13,
                  matrix_p21, matrix_p22, matrix_p23,
                  matrix_p31, matrix_p32, matrix_p33};

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] first_p11, first_p22, first_p33;

  magnitude_window_3x3 #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .DW         (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pixel_valid  (pixel_valid),
    .pixel_data   (pixel_data),
    .matrix_clken (matrix_clken),
    .data_valid   (data_valid),
    .matrix_p11   (matrix_p11),
    .matrix_p12   (matrix_p12),
    .matrix_p13   (matrix_p13),
    .matrix_p21   (matrix_p21),
    .matrix_p22   (matrix_p22),
    .matrix_p23   (matrix_p23),
    .matrix_p31   (matrix_p31),
    .matrix_p32   (matrix_p32),
    .matrix_p33   (matrix_p33),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the capturing edge.
  task automatic step(input logic s, input logic v, input logic [DW-1:0] d);
    @(negedge clk);
    start       = s;
    pixel_valid = v;
    pixel_data  = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pix(input int r, input int c, input logic [DW-1:0] off);
    return off + DW'(r * 16 + c);
  endfunction

  function automatic logic [143:0] exp_win(input int r, input int c, input logic [DW-1:0] off);
    return {pix(r-2, c-2, off), pix(r-2, c-1, off), pix(r-2, c, off),
            pix(r-1, c-2, off), pix(r-1, c-1, off), pix(r-1, c, off),
            pix(r,   c-2, off), pix(r,   c-1, off), pix(r,   c, off)};
  endfunction

  // One full ramp frame; gap idle cycles (start high, valid low) after each pixel.
  task automatic run_frame(input logic [DW-1:0] off, input int gap);
    int   nvalid;
    int   ndone;
    logic exp_dv;
    logic exp_last;
    nvalid = 0;
    ndone  = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        step(1'b1, 1'b1, pix(r, c, off));
        exp_dv   = (r < 2) || (c < 2);
        exp_last = (r == H-1) && (c == W-1);
        check("clken_on_accept", 144'(matrix_clken), 144'(1'b1));
        check("data_valid",      144'(data_valid),   144'(exp_dv));
        check("frame_done",      144'(frame_done),   144'(exp_last));
        if (frame_done) ndone++;
        if (!exp_dv) begin
          check("window", w_win, exp_win(r, c, off));
          nvalid++;
          if (nvalid == 1) begin
            first_p11 = matrix_p11;
            first_p22 = matrix_p22;
            first_p33 = matrix_p33;
          end
        end
        for (int g = 0; g < gap; g++) begin
          step(1'b1, 1'b0, 16'hDEAD);
          check("clken_idle",      144'(matrix_clken), 144'(1'b0));
          check("done_idle",       144'(frame_done),   144'(1'b0));
          check("data_valid_hold", 144'(data_valid),   144'(exp_dv));
          if (!exp_dv) check("window_hold", w_win, exp_win(r, c, off));
        end
      end
    end
    check("valid_window_count", 144'(nvalid), 144'(6));
    check("frame_done_count",   144'(ndone),  144'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    pixel_valid = 1'b0;
    pixel_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_clken",  144'(matrix_clken), 144'(1'b0));
    check("rst_dv",     144'(data_valid),   144'(1'b1));
    check("rst_done",   144'(frame_done),   144'(1'b0));
    check("rst_window", w_win,              144'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // A few accepts, then an asynchronous reset between edges.
    step(1'b1, 1'b1, 16'h00AB);
    check("first_clken", 144'(matrix_clken), 144'(1'b1));
    check("first_dv",    144'(data_valid),   144'(1'b1));
    check("first_p33",   144'(matrix_p33),   144'(16'h00AB));
    step(1'b1, 1'b1, 16'h00CD);
    step(1'b1, 1'b1, 16'h00EF);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_clken",  144'(matrix_clken), 144'(1'b0));
    check("async_rst_dv",     144'(data_valid),   144'(1'b1));
    check("async_rst_window", w_win,              144'(0));
    @(negedge clk);
    rst_n       = 1'b1;
    start       = 1'b0;
    pixel_valid = 1'b0;

    // Continuous ramp frame followed back-to-back by an offset frame.
    run_frame(16'h0000, 0);
    check("ramp_first_p11", 144'(first_p11), 144'(16'h0000));
    check("ramp_first_p22", 144'(first_p22), 144'(16'h0011));
    check("ramp_first_p33", 144'(first_p33), 144'(16'h0022));
    run_frame(16'h0080, 0);
    check("b2b_first_p11", 144'(first_p11), 144'(16'h0080));
    check("b2b_first_p22", 144'(first_p22), 144'(16'h0091));

    // Same ramp with pixel_valid high one cycle in three.
    run_frame(16'h0000, 2);
    check("gap_first_p11", 144'(first_p11), 144'(16'h0000));
    check("gap_first_p33", 144'(first_p33), 144'(16'h0022));

    // Drop start after pixel (1,3), then a fresh frame.
    for (int i = 0; i < W + 4; i++) step(1'b1, 1'b1, 16'h0100 + DW'(i));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 16'h0555);
      check("no_clken_start_low", 144'(matrix_clken), 144'(1'b0));
      check("no_done_start_low",  144'(frame_done),   144'(1'b0));
    end
    run_frame(16'h0040, 0);
    check("restart_first_p22", 144'(first_p22), 144'(16'h0051));
    check("restart_first_p11", 144'(first_p11), 144'(16'h0040));

    // start and pixel_valid fall in the same cycle mid-line.
    step(1'b1, 1'b1, 16'h0200);
    step(1'b1, 1'b1, 16'h0201);
    step(1'b0, 1'b0, 16'h0202);
    check("same_cycle_fall_clken", 144'(matrix_clken), 144'(1'b0));
    run_frame(16'h0020, 0);
    check("after_fall_first_p11", 144'(first_p11), 144'(16'h0020));
    check("after_fall_first_p33", 144'(first_p33), 144'(16'h0042));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_magnitude_window_3x3
